// File: rtl/chess_pkg.sv
// Shared types and constants for the board-scan dispatcher and its generator port.
package chess_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SCAN_RD,
        ST_SCAN_WAIT,
        ST_CHECK,
        ST_G_SRC,
        ST_G_DST,
        ST_G_X,
        ST_G_Y,
        ST_G_GO,
        ST_G_SETTLE,
        ST_G_POLL,
        ST_ADVANCE,
        ST_DONE
    } dispatch_state_t;

    typedef logic signed [7:0] square_t;

    localparam int unsigned BOARD_SQUARES = 64;
    localparam int unsigned BOARD_BYTES   = 256;
    localparam square_t     EMPTY_SQ      = 8'sd0;

    localparam logic [3:0] REG_START = 4'd0;
    localparam logic [3:0] REG_SRC   = 4'd1;
    localparam logic [3:0] REG_DST   = 4'd2;
    localparam logic [3:0] REG_X     = 4'd3;
    localparam logic [3:0] REG_Y     = 4'd4;

endpackage

// File: rtl/gen_port_ctl.sv
// Single-transfer Avalon master: a req pulse launches one read or write, done pulses after accept.
module gen_port_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_write,
    input  logic [3:0]  req_address,
    input  logic [31:0] req_writedata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [3:0]  gen_address,
    output logic        gen_read,
    output logic        gen_write,
    output logic [31:0] gen_writedata,
    input  logic [31:0] gen_readdata,
    input  logic        gen_waitrequest
);

    always_ff @(posedge clk) begin
        if (rst) begin
            done          <= 1'b0;
            rdata         <= '0;
            gen_address   <= '0;
            gen_read      <= 1'b0;
            gen_write     <= 1'b0;
            gen_writedata <= '0;
        end else begin
            done <= 1'b0;
            if (gen_read || gen_write) begin
                // Address, data and strobe are held untouched until the slave accepts.
                if (!gen_waitrequest) begin
                    gen_read  <= 1'b0;
                    gen_write <= 1'b0;
                    done      <= 1'b1;
                    if (gen_read)
                        rdata <= gen_readdata;
                end
            end else if (req) begin
                gen_address   <= req_address;
                gen_writedata <= req_writedata;
                gen_write     <= req_write;
                gen_read      <= !req_write;
            end
        end
    end

endmodule

// File: rtl/gen_dispatch.sv
// Board-scan dispatcher: reads 64 squares, issues one generator job per pawn of the side to move.
// Optional DISPATCH_PERF_EN adds busy-cycle (reg5) and jobs-issued (reg6) counters.
module gen_dispatch
    import chess_pkg::*;
#(
    parameter int unsigned PAWN_CODE       = 1,
    parameter int unsigned MOVES_PER_PIECE = 4,
    parameter int unsigned MAX_BOARDS      = 64,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    input  logic        slave_write,
    output logic [31:0] slave_readdata,
    input  logic [31:0] slave_writedata,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic [3:0]  gen_address,
    output logic        gen_read,
    output logic        gen_write,
    output logic [31:0] gen_writedata,
    input  logic [31:0] gen_readdata,
    input  logic        gen_waitrequest
);

    localparam logic [3:0] CPU_RESULT = 4'd0;
    localparam logic [3:0] CPU_SRC    = 4'd1;
    localparam logic [3:0] CPU_OUT    = 4'd2;
    localparam logic [3:0] CPU_COLOR  = 4'd3;
    localparam logic [3:0] CPU_BUSY   = 4'd5;
    localparam logic [3:0] CPU_JOBS   = 4'd6;
    localparam square_t    PAWN_POS   = 8'(PAWN_CODE);
    localparam square_t    PAWN_NEG   = -PAWN_POS;

    dispatch_state_t state;
    logic [31:0] src_addr, out_addr, out_ptr;
    logic        color, overflow;
    logic [5:0]  sq, sq_next;
    logic [15:0] total, settle_cnt;
    square_t     pc;
    logic        gp_req, gp_write, gp_done;
    logic [3:0]  gp_addr;
    logic [31:0] gp_wdata, gp_rdata;
    logic [2:0]  n;
    logic        pawn_hit, would_overflow, settle_last, start;
    logic [31:0] perf_busy, perf_jobs;
    logic        unused_bits;

    assign sq_next        = sq + 6'd1;
    assign n              = gp_rdata[2:0];
    assign pawn_hit       = color ? (pc == PAWN_NEG) : (pc == PAWN_POS);
    assign would_overflow = (32'(total) + MOVES_PER_PIECE) > MAX_BOARDS;
    assign settle_last    = (32'(settle_cnt) + 32'd1) >= SETTLE_CYCLES;
    assign start          = (state == ST_IDLE) && slave_write && (slave_address == CPU_RESULT);
    assign unused_bits    = ^{master_readdata[31:8], gp_rdata[31:3]};

    gen_port_ctl u_gen_port (
        .clk            (clk),
        .rst            (rst),
        .req            (gp_req),
        .req_write      (gp_write),
        .req_address    (gp_addr),
        .req_writedata  (gp_wdata),
        .done           (gp_done),
        .rdata          (gp_rdata),
        .gen_address    (gen_address),
        .gen_read       (gen_read),
        .gen_write      (gen_write),
        .gen_writedata  (gen_writedata),
        .gen_readdata   (gen_readdata),
        .gen_waitrequest(gen_waitrequest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            src_addr       <= '0;
            out_addr       <= '0;
            out_ptr        <= '0;
            color          <= 1'b0;
            overflow       <= 1'b0;
            sq             <= '0;
            total          <= '0;
            settle_cnt     <= '0;
            pc             <= EMPTY_SQ;
            master_read    <= 1'b0;
            master_address <= '0;
            gp_req         <= 1'b0;
            gp_write       <= 1'b0;
            gp_addr        <= '0;
            gp_wdata       <= '0;
        end else begin
            gp_req <= 1'b0;
            case (state)
                ST_IDLE: if (slave_write) begin
                    case (slave_address)
                        CPU_RESULT: begin
                            state          <= ST_SCAN_RD;
                            sq             <= '0;
                            total          <= '0;
                            out_ptr        <= out_addr;
                            overflow       <= 1'b0;
                            master_read    <= 1'b1;
                            master_address <= src_addr;
                        end
                        CPU_SRC:   src_addr <= slave_writedata;
                        CPU_OUT:   out_addr <= slave_writedata;
                        CPU_COLOR: color    <= slave_writedata[0];
                        default: ;
                    endcase
                end
                ST_SCAN_RD: if (!master_waitrequest) begin
                    master_read <= 1'b0;
                    state       <= ST_SCAN_WAIT;
                end
                ST_SCAN_WAIT: if (master_readdatavalid) begin
                    pc    <= master_readdata[7:0];
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!pawn_hit) begin
                        state <= ST_ADVANCE;
                    end else if (would_overflow) begin
                        overflow <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        state    <= ST_G_SRC;
                        gp_req   <= 1'b1;
                        gp_write <= 1'b1;
                        gp_addr  <= REG_SRC;
                        gp_wdata <= src_addr;
                    end
                end
                // Each gen state launches the next register write once the previous one is accepted.
                ST_G_SRC: if (gp_done) begin
                    state <= ST_G_DST; gp_req <= 1'b1; gp_addr <= REG_DST; gp_wdata <= out_ptr;
                end
                ST_G_DST: if (gp_done) begin
                    state <= ST_G_X; gp_req <= 1'b1; gp_addr <= REG_X; gp_wdata <= {29'd0, sq[2:0]};
                end
                ST_G_X: if (gp_done) begin
                    state <= ST_G_Y; gp_req <= 1'b1; gp_addr <= REG_Y; gp_wdata <= {29'd0, sq[5:3]};
                end
                ST_G_Y: if (gp_done) begin
                    state <= ST_G_GO; gp_req <= 1'b1; gp_addr <= REG_START; gp_wdata <= '0;
                end
                ST_G_GO: if (gp_done) begin
                    state      <= ST_G_SETTLE;
                    settle_cnt <= '0;
                end
                ST_G_SETTLE: begin
                    if (settle_last) begin
                        state    <= ST_G_POLL;
                        gp_req   <= 1'b1;
                        gp_write <= 1'b0;
                        gp_addr  <= REG_START;
                        gp_wdata <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                ST_G_POLL: if (gp_done) begin
                    total   <= total + 16'(n);
                    out_ptr <= out_ptr + 32'(n) * BOARD_BYTES;
                    state   <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (sq == 6'(BOARD_SQUARES - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        sq             <= sq_next;
                        state          <= ST_SCAN_RD;
                        master_read    <= 1'b1;
                        master_address <= src_addr + {24'd0, sq_next, 2'b00};
                    end
                end
                ST_DONE: if (slave_read && slave_address == CPU_RESULT) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            perf_busy <= '0;
            perf_jobs <= '0;
        end else begin
            if (state != ST_IDLE && state != ST_DONE)
                perf_busy <= perf_busy + 32'd1;
            if (state == ST_G_GO && gp_done)
                perf_jobs <= perf_jobs + 32'd1;
        end
    end
`else
    assign perf_busy = '0;
    assign perf_jobs = '0;
`endif

    assign slave_waitrequest = slave_read && (slave_address == CPU_RESULT) &&
                               (state != ST_IDLE) && (state != ST_DONE);

    always_comb begin
        slave_readdata = '0;
        case (slave_address)
            CPU_RESULT: slave_readdata = {overflow, 15'd0, total};
            CPU_SRC:    slave_readdata = src_addr;
            CPU_OUT:    slave_readdata = out_addr;
            CPU_COLOR:  slave_readdata = {31'd0, color};
            CPU_BUSY:   slave_readdata = perf_busy;
            CPU_JOBS:   slave_readdata = perf_jobs;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gen_dispatch.sv
// Scoreboard bench for gen_dispatch with SDRAM and generator bus models.
module tb_gen_dispatch;

    localparam int unsigned MPP  = 4;
    localparam int unsigned MAXB = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0, slave_write = 1'b0;
    logic [31:0] slave_readdata;
    logic [31:0] slave_writedata = '0;
    logic [31:0] master_address;
    logic        master_read;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic [3:0]  gen_address;
    logic        gen_read, gen_write;
    logic [31:0] gen_writedata;
    logic [31:0] gen_readdata = '0;
    logic        gen_waitrequest = 1'b0;

    int total_cnt = 0;
    int bad_cnt = 0;

    logic [31:0] mem [64];
    logic [31:0] src_base, out_base;
    int sdram_stall = 0, gen_stall = 0;
    int sdram_reads = 0, gen_writes = 0;
    logic [31:0] exp_rd_q[$];
    logic [35:0] exp_gw_q[$];
    int gen_n_q[$];

    always #5 clk = ~clk;

    gen_dispatch #(
        .PAWN_CODE(1),
        .MOVES_PER_PIECE(MPP),
        .MAX_BOARDS(MAXB),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_write(slave_write),
        .slave_readdata(slave_readdata), .slave_writedata(slave_writedata),
        .master_address(master_address), .master_read(master_read),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .gen_address(gen_address), .gen_read(gen_read), .gen_write(gen_write),
        .gen_writedata(gen_writedata), .gen_readdata(gen_readdata),
        .gen_waitrequest(gen_waitrequest)
    );

    // SDRAM model: stalls sdram_stall cycles per read, data valid one cycle after accept.
    logic        rv_pend = 1'b0;
    logic [31:0] rv_data = '0;
    int          mstall = 0;
    logic        m_stalled = 1'b0;
    logic [31:0] m_held = '0;
    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] off;
        if (rst) begin
            master_waitrequest = 1'b0; master_readdatavalid = 1'b0;
            rv_pend = 1'b0; mstall = 0; m_stalled = 1'b0;
        end else begin
            master_readdatavalid = rv_pend;
            master_readdata = rv_pend ? rv_data : 32'hDEAD_BEEF;
            rv_pend = 1'b0;
            if (master_read) begin
                if (m_stalled) begin
                    total_cnt++;
                    if (master_address !== m_held) begin
                        bad_cnt++;
                        $display("FAIL sdram_addr_stable: got %h want %h", master_address, m_held);
                    end
                end
                if (mstall < sdram_stall) begin
                    master_waitrequest = 1'b1; mstall++; m_stalled = 1'b1; m_held = master_address;
                end else begin
                    master_waitrequest = 1'b0; mstall = 0; m_stalled = 1'b0;
                    sdram_reads++;
                    total_cnt++;
                    if (exp_rd_q.size() == 0) begin
                        bad_cnt++;
                        $display("FAIL sdram_unexpected_read: got %h want none", master_address);
                    end else begin
                        e = exp_rd_q.pop_front();
                        if (master_address !== e) begin
                            bad_cnt++;
                            $display("FAIL sdram_addr: got %h want %h", master_address, e);
                        end
                    end
                    off = (master_address - src_base) >> 2;
                    rv_pend = 1'b1;
                    rv_data = mem[off[5:0]];
                end
            end else begin
                master_waitrequest = 1'b0;
            end
        end
    end

    // Generator model: stalls gen_stall cycles per transfer, poll returns the next queued count.
    int          gstall = 0;
    logic        g_stalled = 1'b0;
    logic [35:0] g_held = '0;
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst) begin
            gen_waitrequest = 1'b0; gstall = 0; g_stalled = 1'b0;
        end else if (gen_read || gen_write) begin
            if (g_stalled) begin
                total_cnt++;
                if ({gen_address, gen_writedata} !== g_held) begin
                    bad_cnt++;
                    $display("FAIL gen_bus_stable: got %h want %h", {gen_address, gen_writedata}, g_held);
                end
            end
            if (gstall < gen_stall) begin
                gen_waitrequest = 1'b1; gstall++; g_stalled = 1'b1;
                g_held = {gen_address, gen_writedata};
            end else begin
                gen_waitrequest = 1'b0; gstall = 0; g_stalled = 1'b0;
                if (gen_write) begin
                    gen_writes++;
                    total_cnt++;
                    if (exp_gw_q.size() == 0) begin
                        bad_cnt++;
                        $display("FAIL gen_unexpected_write: got %h want none", {gen_address, gen_writedata});
                    end else begin
                        e = exp_gw_q.pop_front();
                        if ({gen_address, gen_writedata} !== e) begin
                            bad_cnt++;
                            $display("FAIL gen_write: got %h want %h", {gen_address, gen_writedata}, e);
                        end
                    end
                end else begin
                    total_cnt++;
                    if (gen_address !== 4'd0) begin
                        bad_cnt++;
                        $display("FAIL gen_poll_addr: got %h want 0", gen_address);
                    end
                    gen_readdata = (gen_n_q.size() != 0) ? 32'(gen_n_q.pop_front()) : 32'hFFFF_FFF8;
                end
            end
        end else begin
            gen_waitrequest = 1'b0;
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        @(posedge clk);
        #1 slave_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, input int budget, output logic [31:0] d, output bit ok);
        int cyc = 0;
        ok = 1'b0; d = 'x;
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        forever begin
            #1;
            if (!slave_waitrequest) begin
                d = slave_readdata; ok = 1'b1;
                break;
            end
            if (cyc >= budget) break;
            cyc++;
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1 slave_read = 1'b0;
    endtask

    task automatic clear_board();
        logic [31:0] r;
        for (int i = 0; i < 64; i++) begin
            r = $urandom();
            mem[i] = {r[31:8], 8'h00};
        end
    endtask

    task automatic put_sq(input int s, input logic [7:0] v);
        mem[s][7:0] = v;
    endtask

    task automatic clear_queues();
        exp_rd_q.delete(); exp_gw_q.delete(); gen_n_q.delete();
    endtask

    // Reference scan: expected SDRAM addresses, generator writes and final result.
    task automatic compute_expect(input logic col, output logic [31:0] res);
        int nq[$];
        logic [15:0] tot;
        logic [31:0] ptr, w;
        logic signed [7:0] v;
        logic ovf;
        int n;
        nq = gen_n_q; tot = '0; ptr = out_base; ovf = 1'b0;
        for (int s = 0; s < 64; s++) begin
            exp_rd_q.push_back(src_base + 32'(s) * 32'd4);
            w = mem[s]; v = w[7:0];
            if ((col == 1'b0 && v == 8'sd1) || (col == 1'b1 && v == -8'sd1)) begin
                if (32'(tot) + MPP > MAXB) begin
                    ovf = 1'b1;
                    break;
                end
                exp_gw_q.push_back({4'd1, src_base});
                exp_gw_q.push_back({4'd2, ptr});
                exp_gw_q.push_back({4'd3, 32'(s % 8)});
                exp_gw_q.push_back({4'd4, 32'(s / 8)});
                exp_gw_q.push_back({4'd0, 32'd0});
                n = (nq.size() != 0) ? nq.pop_front() : 0;
                tot = tot + 16'(n);
                ptr = ptr + 32'(n) * 32'd256;
            end
        end
        res = {ovf, 15'd0, tot};
    endtask

    task automatic run_job(input string name, input logic col, input logic [31:0] want);
        logic [31:0] exp_res, d;
        bit ok;
        int exp_rds, exp_gws;
        sdram_reads = 0; gen_writes = 0;
        compute_expect(col, exp_res);
        exp_rds = exp_rd_q.size(); exp_gws = exp_gw_q.size();
        total_cnt++;
        if (exp_res !== want) begin
            bad_cnt++;
            $display("FAIL %s_model_result: got %h want %h", name, exp_res, want);
        end
        cpu_write(4'd1, src_base);
        cpu_write(4'd2, out_base);
        cpu_write(4'd3, {31'd0, col});
        cpu_write(4'd0, 32'd0);
        cpu_read(4'd0, 20000, d, ok);
        total_cnt++;
        if (!ok) begin
            bad_cnt++;
            $display("FAIL %s_timeout: got stalled want done", name);
        end
        total_cnt++;
        if (d !== want) begin
            bad_cnt++;
            $display("FAIL %s_result: got %h want %h", name, d, want);
        end
        repeat (2) @(posedge clk);
        total_cnt++;
        if (sdram_reads != exp_rds || exp_rd_q.size() != 0) begin
            bad_cnt++;
            $display("FAIL %s_sdram_reads: got %0d want %0d", name, sdram_reads, exp_rds);
        end
        total_cnt++;
        if (gen_writes != exp_gws || exp_gw_q.size() != 0 || gen_n_q.size() != 0) begin
            bad_cnt++;
            $display("FAIL %s_gen_writes: got %0d want %0d", name, gen_writes, exp_gws);
        end
        cpu_read(4'd0, 2, d, ok);
        total_cnt++;
        if (!ok || d !== want) begin
            bad_cnt++;
            $display("FAIL %s_reread_idle: got %h want %h", name, d, want);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ok;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({master_read, gen_read, gen_write, slave_waitrequest} !== 4'b0000) begin
            bad_cnt++;
            $display("FAIL reset_strobes: got %b want 0000", {master_read, gen_read, gen_write, slave_waitrequest});
        end
        total_cnt++;
        if (master_address !== 32'd0 || gen_address !== 4'd0 || gen_writedata !== 32'd0) begin
            bad_cnt++;
            $display("FAIL reset_buses: got %h/%h/%h want 0", master_address, gen_address, gen_writedata);
        end
        @(negedge clk) rst = 1'b0;
        for (int unsigned a = 0; a < 7; a++) begin
            if (a == 4) continue;
            cpu_read(4'(a), 2, d, ok);
            total_cnt++;
            if (!ok || d !== 32'd0) begin
                bad_cnt++;
                $display("FAIL reset_reg%0d: got %h want 00000000", a, d);
            end
        end
    endtask

    task automatic test_empty();
        clear_queues(); clear_board();
        put_sq(5, 8'h02); put_sq(40, 8'hFF);
        src_base = 32'h0000_1000; out_base = 32'h0010_0000;
        run_job("empty_white", 1'b0, 32'h0000_0000);
    endtask

    task automatic test_single_white();
        clear_queues(); clear_board();
        put_sq(12, 8'h01); put_sq(20, 8'hFF); put_sq(30, 8'h02);
        gen_n_q.push_back(2);
        src_base = 32'h0000_2000; out_base = 32'h0020_0000;
        run_job("single_white", 1'b0, 32'h0000_0002);
    endtask

    task automatic test_two_black();
        clear_queues(); clear_board();
        put_sq(0, 8'h01); put_sq(48, 8'hFF); put_sq(55, 8'hFF); put_sq(60, 8'hFE);
        gen_n_q.push_back(3); gen_n_q.push_back(1);
        src_base = 32'hFFFF_FF80; out_base = 32'h0030_0000;
        run_job("two_black", 1'b1, 32'h0000_0004);
    endtask

    task automatic test_overflow();
        clear_queues(); clear_board();
        for (int s = 8; s <= 24; s++) put_sq(s, 8'h01);
        for (int i = 0; i < 16; i++) gen_n_q.push_back(4);
        src_base = 32'h0000_4000; out_base = 32'h0040_0000;
        run_job("overflow", 1'b0, 32'h8000_0040);
    endtask

    task automatic test_stall();
        clear_queues(); clear_board();
        put_sq(12, 8'h01);
        gen_n_q.push_back(2);
        src_base = 32'h0000_5000; out_base = 32'h0050_0000;
        sdram_stall = 5; gen_stall = 7;
        run_job("stall", 1'b0, 32'h0000_0002);
        sdram_stall = 0; gen_stall = 0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] d, unused_res;
        bit ok, seen;
        int cyc;
        clear_queues(); clear_board();
        put_sq(12, 8'h01);
        gen_n_q.push_back(2);
        src_base = 32'h0000_6000; out_base = 32'h0060_0000;
        gen_stall = 7;
        compute_expect(1'b0, unused_res);
        cpu_write(4'd1, src_base);
        cpu_write(4'd2, out_base);
        cpu_write(4'd3, 32'd0);
        cpu_write(4'd0, 32'd0);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            if (gen_read === 1'b1) seen = 1'b1;
            cyc++;
        end
        total_cnt++;
        if (!seen) begin
            bad_cnt++;
            $display("FAIL midop_reach_poll: got no poll want poll");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({master_read, gen_read, gen_write, slave_waitrequest} !== 4'b0000) begin
            bad_cnt++;
            $display("FAIL midop_strobes: got %b want 0000", {master_read, gen_read, gen_write, slave_waitrequest});
        end
        @(negedge clk) rst = 1'b0;
        gen_stall = 0;
        clear_queues();
        cpu_read(4'd1, 2, d, ok);
        total_cnt++;
        if (!ok || d !== 32'd0) begin
            bad_cnt++;
            $display("FAIL midop_src_cleared: got %h want 00000000", d);
        end
        gen_n_q.push_back(2);
        run_job("after_reset", 1'b0, 32'h0000_0002);
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_white();
        test_two_black();
        test_overflow();
        test_stall();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
